// File: rtl/gomoku_ui_pkg.sv
// Shared geometry, stone encodings and palette for the Gomoku VGA pixel path.
package gomoku_ui_pkg;

    localparam int N_DEF          = 15;
    localparam int CELL_DEF       = 30;
    localparam int X0_DEF         = 95;
    localparam int Y0_DEF         = 15;
    localparam int R2_DEF         = 144;
    localparam int BLINK_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10,
        WIN   = 2'b11
    } stone_t;

    localparam logic [11:0] COL_OFF    = 12'h000;
    localparam logic [11:0] COL_BG     = 12'h222;
    localparam logic [11:0] COL_CURSOR = 12'h0F0;
    localparam logic [11:0] COL_BLACK  = 12'h111;
    localparam logic [11:0] COL_WHITE  = 12'hEEE;
    localparam logic [11:0] COL_WIN    = 12'hF00;
    localparam logic [11:0] COL_GRID   = 12'h000;
    localparam logic [11:0] COL_WOOD   = 12'hDA6;

endpackage

// File: rtl/board_renderer_if.sv
// Timing-controller inputs, board RAM read port and VGA outputs of the renderer.
interface board_renderer_if;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic [7:0] board_addr;
    logic [1:0] board_data;
    logic [3:0] vgaRed;
    logic [3:0] vgaGreen;
    logic [3:0] vgaBlue;
    logic       hsync;
    logic       vsync;

    modport slave (
        input  h_cnt, v_cnt, valid, hsync_in, vsync_in, cur_row, cur_col, board_data,
        output board_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync
    );

    modport master (
        output h_cnt, v_cnt, valid, hsync_in, vsync_in, cur_row, cur_col, board_data,
        input  board_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync
    );
endinterface

// File: rtl/board_renderer_blink_timer.sv
// Counts vsync falling edges; the cursor is shown while the top counter bit is clear.
module blink_timer #(
    parameter int BLINK_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_blink_on
);

    logic                  r_vs_d;
    logic [BLINK_LOG2:0]   r_frame_cnt;
    logic                  w_vs_fall;

    assign w_vs_fall  = r_vs_d & ~i_vsync;
    assign o_blink_on = ~r_frame_cnt[BLINK_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d      <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_vs_d <= i_vsync;
            if (w_vs_fall)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Three-stage pixel colour pipeline: cell decode, board RAM read + stone geometry, colour select.
module board_renderer
    import gomoku_ui_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int CELL       = CELL_DEF,
    parameter int X0         = X0_DEF,
    parameter int Y0         = Y0_DEF,
    parameter int R2         = R2_DEF,
    parameter int BLINK_LOG2 = BLINK_LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst,
    board_renderer_if.slave io_vga
);

    localparam logic [9:0]  X0_W   = 10'(X0);
    localparam logic [9:0]  Y0_W   = 10'(Y0);
    localparam logic [9:0]  X_END  = 10'(X0 + N * CELL);
    localparam logic [9:0]  Y_END  = 10'(Y0 + N * CELL);
    localparam logic [9:0]  CELL_W = 10'(CELL);
    localparam logic [3:0]  N_4    = 4'(N);
    localparam logic [7:0]  N_8    = 8'(N);
    localparam logic [4:0]  HALF   = 5'(CELL / 2);
    localparam logic [4:0]  EDGE_L = 5'd2;
    localparam logic [4:0]  EDGE_H = 5'(CELL - 2);
    localparam logic [10:0] R2_W   = 11'(R2);

    // S1 combinational decode
    logic [9:0] w_hx, w_vy;
    logic       w_in_board;
    logic [3:0] w_col, w_row;
    logic [4:0] w_xoff, w_yoff;
    logic       w_cur_match;

    assign w_hx       = io_vga.h_cnt - X0_W;
    assign w_vy       = io_vga.v_cnt - Y0_W;
    assign w_in_board = io_vga.valid
                        && (io_vga.h_cnt >= X0_W) && (io_vga.h_cnt < X_END)
                        && (io_vga.v_cnt >= Y0_W) && (io_vga.v_cnt < Y_END);
    assign w_col      = w_in_board ? 4'(w_hx / CELL_W) : 4'd0;
    assign w_row      = w_in_board ? 4'(w_vy / CELL_W) : 4'd0;
    assign w_xoff     = w_in_board ? 5'(w_hx % CELL_W) : 5'd0;
    assign w_yoff     = w_in_board ? 5'(w_vy % CELL_W) : 5'd0;
    assign w_cur_match = w_in_board && (io_vga.cur_row < N_4) && (io_vga.cur_col < N_4)
                         && (w_row == io_vga.cur_row) && (w_col == io_vga.cur_col);

    logic       r1_valid, r1_in_board, r1_cur, r1_hs, r1_vs;
    logic [3:0] r1_row, r1_col;
    logic [4:0] r1_xoff, r1_yoff;

    logic       r2_valid, r2_in_board, r2_cur, r2_hs, r2_vs;
    logic [4:0] r2_xoff, r2_yoff;

    logic [11:0] r_rgb;
    logic        r_hsync, r_vsync;

    logic w_blink_on;

    blink_timer #(.BLINK_LOG2(BLINK_LOG2)) u_blink (
        .clk        (clk),
        .rst        (rst),
        .i_vsync    (io_vga.vsync_in),
        .o_blink_on (w_blink_on)
    );

    assign io_vga.board_addr = r1_in_board ? (8'(r1_row) * N_8 + 8'(r1_col)) : 8'd0;

    // Stone geometry on S2 offsets; |d| squared equals signed d squared
    logic [4:0]  w_adx, w_ady;
    logic [10:0] w_d2;
    logic        w_in_stone, w_on_edge, w_on_grid;

    assign w_adx      = (r2_xoff >= HALF) ? (r2_xoff - HALF) : (HALF - r2_xoff);
    assign w_ady      = (r2_yoff >= HALF) ? (r2_yoff - HALF) : (HALF - r2_yoff);
    assign w_d2       = 11'(w_adx) * 11'(w_adx) + 11'(w_ady) * 11'(w_ady);
    assign w_in_stone = (w_d2 <= R2_W);
    assign w_on_edge  = (r2_xoff < EDGE_L) || (r2_xoff >= EDGE_H)
                        || (r2_yoff < EDGE_L) || (r2_yoff >= EDGE_H);
    assign w_on_grid  = (r2_xoff == HALF) || (r2_yoff == HALF);

    logic [11:0] w_rgb;

    always_comb begin
        w_rgb = COL_WOOD;
        if (!r2_valid)
            w_rgb = COL_OFF;
        else if (!r2_in_board)
            w_rgb = COL_BG;
        else if (r2_cur && w_blink_on && w_on_edge)
            w_rgb = COL_CURSOR;
        else if (w_in_stone && (stone_t'(io_vga.board_data) != EMPTY)) begin
            case (stone_t'(io_vga.board_data))
                BLACK:   w_rgb = COL_BLACK;
                WHITE:   w_rgb = COL_WHITE;
                default: w_rgb = COL_WIN;
            endcase
        end else if (w_on_grid)
            w_rgb = COL_GRID;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_in_board <= 1'b0;
            r1_cur      <= 1'b0;
            r1_hs       <= 1'b1;
            r1_vs       <= 1'b1;
            r1_row      <= '0;
            r1_col      <= '0;
            r1_xoff     <= '0;
            r1_yoff     <= '0;
            r2_valid    <= 1'b0;
            r2_in_board <= 1'b0;
            r2_cur      <= 1'b0;
            r2_hs       <= 1'b1;
            r2_vs       <= 1'b1;
            r2_xoff     <= '0;
            r2_yoff     <= '0;
            r_rgb       <= COL_OFF;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
        end else begin
            r1_valid    <= io_vga.valid;
            r1_in_board <= w_in_board;
            r1_cur      <= w_cur_match;
            r1_hs       <= io_vga.hsync_in;
            r1_vs       <= io_vga.vsync_in;
            r1_row      <= w_row;
            r1_col      <= w_col;
            r1_xoff     <= w_xoff;
            r1_yoff     <= w_yoff;
            r2_valid    <= r1_valid;
            r2_in_board <= r1_in_board;
            r2_cur      <= r1_cur;
            r2_hs       <= r1_hs;
            r2_vs       <= r1_vs;
            r2_xoff     <= r1_xoff;
            r2_yoff     <= r1_yoff;
            r_rgb       <= w_rgb;
            r_hsync     <= r2_hs;
            r_vsync     <= r2_vs;
        end
    end

    assign io_vga.vgaRed   = r_rgb[11:8];
    assign io_vga.vgaGreen = r_rgb[7:4];
    assign io_vga.vgaBlue  = r_rgb[3:0];
    assign io_vga.hsync    = r_hsync;
    assign io_vga.vsync    = r_vsync;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer with a one-cycle-latency board RAM model.
module tb_board_renderer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [1:0] mem [0:224];

    board_renderer_if bus ();

    board_renderer dut (
        .clk    (clk),
        .rst    (rst),
        .io_vga (bus.slave)
    );

    always #20 clk = ~clk;

    always @(posedge clk) bus.board_data <= mem[bus.board_addr];

    function automatic logic [11:0] rgb_now();
        return {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
    endfunction

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic vld);
        bus.h_cnt = h;
        bus.v_cnt = v;
        bus.valid = vld;
    endtask

    // Applies one pixel and holds it; returns board_addr after 1 clk and RGB after 3 clk.
    task automatic run_pixel(input logic [9:0] h, input logic [9:0] v, input logic vld,
                             output logic [7:0] addr, output logic [11:0] rgb);
        @(negedge clk);
        drive(h, v, vld);
        @(posedge clk); #1;
        addr = bus.board_addr;
        @(posedge clk);
        @(posedge clk); #1;
        rgb = rgb_now();
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] rgb;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b1;
        drive(10'd100, 10'd20, 1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rgb = rgb_now();
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL reset_rgb: got %h want 000", rgb); n_mis++; end
        n_cmp++; if (bus.hsync !== 1'b1) begin $display("FAIL reset_hsync: got %b want 1", bus.hsync); n_mis++; end
        n_cmp++; if (bus.vsync !== 1'b1) begin $display("FAIL reset_vsync: got %b want 1", bus.vsync); n_mis++; end
        n_cmp++; if (bus.board_addr !== 8'd0) begin $display("FAIL reset_addr: got %0d want 0", bus.board_addr); n_mis++; end
        @(negedge clk);
        bus.hsync_in = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_empty();
        logic [7:0] addr; logic [11:0] rgb;
        run_pixel(10'd100, 10'd20, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'hDA6) begin $display("FAIL empty_wood: got %h want DA6", rgb); n_mis++; end
        run_pixel(10'd110, 10'd20, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL empty_grid: got %h want 000", rgb); n_mis++; end
    endtask

    task automatic test_black_stone();
        logic [7:0] addr; logic [11:0] rgb;
        mem[0] = 2'b01;
        run_pixel(10'd110, 10'd30, 1'b1, addr, rgb);
        n_cmp++; if (addr !== 8'd0) begin $display("FAIL black_addr: got %0d want 0", addr); n_mis++; end
        n_cmp++; if (rgb !== 12'h111) begin $display("FAIL black_stone: got %h want 111", rgb); n_mis++; end
        run_pixel(10'd110, 10'd43, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL black_outside_grid: got %h want 000", rgb); n_mis++; end
    endtask

    task automatic test_corner_stones();
        logic [7:0] addr; logic [11:0] rgb;
        mem[224] = 2'b10;
        run_pixel(10'd530, 10'd450, 1'b1, addr, rgb);
        n_cmp++; if (addr !== 8'd224) begin $display("FAIL corner_addr: got %0d want 224", addr); n_mis++; end
        n_cmp++; if (rgb !== 12'hEEE) begin $display("FAIL white_stone: got %h want EEE", rgb); n_mis++; end
        mem[224] = 2'b11;
        run_pixel(10'd530, 10'd450, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'hF00) begin $display("FAIL win_stone: got %h want F00", rgb); n_mis++; end
    endtask

    task automatic test_boundary();
        logic [7:0] addr; logic [11:0] rgb;
        run_pixel(10'd545, 10'd100, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h222) begin $display("FAIL right_edge: got %h want 222", rgb); n_mis++; end
        n_cmp++; if (addr !== 8'd0) begin $display("FAIL outside_addr: got %0d want 0", addr); n_mis++; end
        run_pixel(10'd300, 10'd465, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h222) begin $display("FAIL bottom_edge: got %h want 222", rgb); n_mis++; end
        run_pixel(10'd94, 10'd100, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h222) begin $display("FAIL left_edge: got %h want 222", rgb); n_mis++; end
        run_pixel(10'd110, 10'd30, 1'b0, addr, rgb);
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL invalid_pixel: got %h want 000", rgb); n_mis++; end
    endtask

    task automatic test_sync_delay();
        logic exp;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.hsync_in = (i < 5) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            exp = (i >= 2 && i <= 6) ? 1'b0 : 1'b1;
            n_cmp++;
            if (bus.hsync !== exp) begin
                $display("FAIL hsync_delay[%0d]: got %b want %b", i, bus.hsync, exp); n_mis++;
            end
        end
    endtask

    task automatic vsync_falls(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); bus.vsync_in = 1'b0;
            @(negedge clk); bus.vsync_in = 1'b1;
        end
    endtask

    task automatic test_cursor();
        logic [7:0] addr; logic [11:0] rgb;
        pulse_reset();
        bus.cur_row = 4'd0;
        bus.cur_col = 4'd0;
        run_pixel(10'd95, 10'd15, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h0F0) begin $display("FAIL cursor_on: got %h want 0F0", rgb); n_mis++; end
        vsync_falls(16);
        run_pixel(10'd95, 10'd15, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'hDA6) begin $display("FAIL cursor_blink_off: got %h want DA6", rgb); n_mis++; end
        vsync_falls(16);
        run_pixel(10'd95, 10'd15, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'h0F0) begin $display("FAIL cursor_blink_on: got %h want 0F0", rgb); n_mis++; end
        bus.cur_row = 4'd15;
        run_pixel(10'd95, 10'd15, 1'b1, addr, rgb);
        n_cmp++; if (rgb !== 12'hDA6) begin $display("FAIL cursor_none: got %h want DA6", rgb); n_mis++; end
        bus.cur_col = 4'd15;
    endtask

    task automatic test_reset_midline();
        logic [7:0] addr; logic [11:0] rgb;
        run_pixel(10'd530, 10'd450, 1'b1, addr, rgb);
        @(negedge clk);
        bus.hsync_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rgb = rgb_now();
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL midrst_rgb: got %h want 000", rgb); n_mis++; end
        n_cmp++; if (bus.hsync !== 1'b1) begin $display("FAIL midrst_hsync: got %b want 1", bus.hsync); n_mis++; end
        n_cmp++; if (bus.vsync !== 1'b1) begin $display("FAIL midrst_vsync: got %b want 1", bus.vsync); n_mis++; end
        n_cmp++; if (bus.board_addr !== 8'd0) begin $display("FAIL midrst_addr: got %0d want 0", bus.board_addr); n_mis++; end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.board_addr !== 8'd224) begin $display("FAIL resume_addr: got %0d want 224", bus.board_addr); n_mis++; end
        @(posedge clk); #1;
        rgb = rgb_now();
        n_cmp++; if (rgb !== 12'h000) begin $display("FAIL resume_early: got %h want 000", rgb); n_mis++; end
        @(posedge clk); #1;
        rgb = rgb_now();
        n_cmp++; if (rgb !== 12'hF00) begin $display("FAIL resume_rgb: got %h want F00", rgb); n_mis++; end
        n_cmp++; if (bus.hsync !== 1'b0) begin $display("FAIL resume_hsync: got %b want 0", bus.hsync); n_mis++; end
        @(negedge clk);
        bus.hsync_in = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 225; i++) mem[i] = 2'b00;
        bus.cur_row  = 4'd15;
        bus.cur_col  = 4'd15;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        drive(10'd0, 10'd0, 1'b0);
        test_reset();
        test_empty();
        test_black_stone();
        test_corner_stones();
        test_boundary();
        test_sync_delay();
        test_cursor();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
